// File: rtl/axi_settings_master.sv
// AXI4-Lite slave that turns write/read transactions into single-cycle
// settings-bus strobes. Write and read channels run as independent FSMs.
module axi_settings_master #(
  parameter int C_DATAWIDTH = 32,
  parameter int C_ADDRWIDTH = 32,
  parameter int C_PAGEWIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [C_ADDRWIDTH-1:0]   s_axi_awaddr,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [C_DATAWIDTH-1:0]   s_axi_wdata,
  input  logic [C_DATAWIDTH/8-1:0] s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  input  logic [C_ADDRWIDTH-1:0]   s_axi_araddr,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [C_DATAWIDTH-1:0]   s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  output logic [C_DATAWIDTH-1:0]   set_data,
  output logic                     set_stb,
  output logic [C_ADDRWIDTH-1:0]   set_addr,
  input  logic [C_DATAWIDTH-1:0]   get_data,
  output logic                     get_stb,
  output logic [C_ADDRWIDTH-1:0]   get_addr
);

  localparam int STRBW = C_DATAWIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_STB, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_STB, R_RESP} r_state_t;

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  w_state_t                 w_state, w_next;
  logic                     aw_latched, w_latched;
  logic [C_PAGEWIDTH-1:0]   awaddr_q;
  logic [C_DATAWIDTH-1:0]   wdata_q;
  logic [STRBW-1:0]         wstrb_q;
  logic                     strobe_ok;
  logic [C_PAGEWIDTH-1:0]   set_page_q;
  logic [C_DATAWIDTH-1:0]   set_data_q;

  logic                     aw_hs, w_hs, both_ready;
  logic [C_PAGEWIDTH-1:0]   eff_page;
  logic [C_DATAWIDTH-1:0]   eff_data;
  logic [STRBW-1:0]         eff_strb;

  // Only the low page bits reach the settings bus; the rest are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[C_ADDRWIDTH-1:C_PAGEWIDTH],
                              s_axi_araddr[C_ADDRWIDTH-1:C_PAGEWIDTH]};

  assign s_axi_awready = (w_state == W_IDLE) && !aw_latched;
  assign s_axi_wready  = (w_state == W_IDLE) && !w_latched;
  assign aw_hs         = s_axi_awvalid && s_axi_awready;
  assign w_hs          = s_axi_wvalid && s_axi_wready;
  assign both_ready    = (aw_latched || aw_hs) && (w_latched || w_hs);

  // The beat that completes the pair may arrive this cycle, so take it
  // straight from the bus when it has not been latched yet.
  assign eff_page = aw_latched ? awaddr_q : s_axi_awaddr[C_PAGEWIDTH-1:0];
  assign eff_data = w_latched  ? wdata_q  : s_axi_wdata;
  assign eff_strb = w_latched  ? wstrb_q  : s_axi_wstrb;

  // Write FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  // Write FSM next-state and strobe/response decode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // (which would infer a latch).
    w_next       = w_state;
    set_stb      = 1'b0;
    s_axi_bvalid = 1'b0;
    s_axi_bresp  = RESP_OKAY;
    unique case (w_state)
      W_IDLE: if (both_ready) w_next = W_STB;
      W_STB: begin
        set_stb = strobe_ok;
        w_next  = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bresp  = strobe_ok ? RESP_OKAY : RESP_SLVERR;
        if (s_axi_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Write channel latches and settings-bus write registers.
  always_ff @(posedge clk) begin
    // NOTE: data registers are reset too, because they drive visible outputs
    // that must read zero out of reset.
    if (rst) begin
      aw_latched <= 1'b0;
      w_latched  <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      strobe_ok  <= 1'b0;
      set_page_q <= '0;
      set_data_q <= '0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_latched <= 1'b1;
            awaddr_q   <= s_axi_awaddr[C_PAGEWIDTH-1:0];
          end
          if (w_hs) begin
            w_latched <= 1'b1;
            wdata_q   <= s_axi_wdata;
            wstrb_q   <= s_axi_wstrb;
          end
          if (both_ready) begin
            strobe_ok <= &eff_strb;
            // Partial writes are refused; the bus keeps its previous value.
            if (&eff_strb) begin
              set_page_q <= eff_page;
              set_data_q <= eff_data;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            aw_latched <= 1'b0;
            w_latched  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign set_addr = {{(C_ADDRWIDTH-C_PAGEWIDTH){1'b0}}, set_page_q};
  assign set_data = set_data_q;

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  r_state_t               r_state, r_next;
  logic                   ar_hs;
  logic [C_PAGEWIDTH-1:0] get_page_q;
  logic [C_DATAWIDTH-1:0] rdata_q;

  assign s_axi_arready = (r_state == R_IDLE);
  assign ar_hs         = s_axi_arvalid && s_axi_arready;

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  // Read FSM next-state and strobe/response decode.
  always_comb begin
    r_next       = r_state;
    get_stb      = 1'b0;
    s_axi_rvalid = 1'b0;
    unique case (r_state)
      R_IDLE: if (ar_hs) r_next = R_STB;
      R_STB: begin
        get_stb = 1'b1;
        r_next  = R_RESP;
      end
      R_RESP: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Read address latch and capture of the responder's data during the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      get_page_q <= '0;
      rdata_q    <= '0;
    end else begin
      if (ar_hs)              get_page_q <= s_axi_araddr[C_PAGEWIDTH-1:0];
      if (r_state == R_STB)   rdata_q    <= get_data;
    end
  end

  assign get_addr    = {{(C_ADDRWIDTH-C_PAGEWIDTH){1'b0}}, get_page_q};
  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = RESP_OKAY;

endmodule
